spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_if.sv | 25 ++
 rtl/spi_slave.sv | 214 +++++++++++++++++++++
 tb/tb_spi_slave.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// SPI slave bus bundle: serial pins plus the byte-level tx/rx handshake.
interface spi_slave_if;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_overrun;
    logic       busy;

    modport slave (
        input  sclk, cs, mosi, tx_data, tx_load, rx_ack,
        output miso, tx_ready, rx_data, rx_valid, rx_overrun, busy
    );

    modport master (
        output sclk, cs, mosi, tx_data, tx_load, rx_ack,
        input  miso, tx_ready, rx_data, rx_valid, rx_overrun, busy
    );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled on clk, one-byte tx holding register and rx output register.
// Optional sticky rx overrun flag enabled by defining SPI_SLAVE_OVERRUN_EN.
module spi_slave #(
    parameter int SYNC_STAGES = 32'd2
) (
    input  logic        clk,
    input  logic        reset_n,
    spi_slave_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int LAST = SYNC_STAGES - 32'd1;

    logic [LAST:0]        sclk_sync_r;
    logic [LAST:0]        cs_sync_r;
    logic [LAST:0]        mosi_sync_r;
    logic                 sclk_dly_r;
    logic                 cs_dly_r;
    logic                 mosi_dly_r;
    logic                 rise_r;
    logic                 fall_r;
    logic [SYNC_STAGES:0] sync_vld_r;

    state_t               state_r;
    logic                 armed_r;
    logic [2:0]           bit_cnt_r;
    logic [7:0]           tx_shift_r;
    logic [7:0]           rx_shift_r;
    logic                 reload_pend_r;
    logic                 miso_r;
    logic                 busy_r;
    logic [7:0]           hold_r;
    logic                 tx_ready_r;
    logic [7:0]           rx_data_r;
    logic                 rx_valid_r;
    logic                 rx_overrun_r;

    logic [7:0]           tx_src_s;
    logic                 start_s;
    logic                 reload_s;
    logic                 done_s;

    // Input synchronizers; edge pulses are registered so mosi_dly_r/cs_dly_r line up with them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_r <= '0;
            cs_sync_r   <= '1;
            mosi_sync_r <= '0;
            sclk_dly_r  <= 1'b0;
            cs_dly_r    <= 1'b1;
            mosi_dly_r  <= 1'b0;
            rise_r      <= 1'b0;
            fall_r      <= 1'b0;
            sync_vld_r  <= '0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[LAST-32'd1:0], bus.sclk};
            cs_sync_r   <= {cs_sync_r[LAST-32'd1:0], bus.cs};
            mosi_sync_r <= {mosi_sync_r[LAST-32'd1:0], bus.mosi};
            sclk_dly_r  <= sclk_sync_r[LAST];
            cs_dly_r    <= cs_sync_r[LAST];
            mosi_dly_r  <= mosi_sync_r[LAST];
            rise_r      <= sclk_sync_r[LAST] & ~sclk_dly_r;
            fall_r      <= ~sclk_sync_r[LAST] & sclk_dly_r;
            sync_vld_r  <= {sync_vld_r[SYNC_STAGES-32'd1:0], 1'b1};
        end
    end

    // Frame start, tx reload and byte completion conditions.
    always_comb begin
        tx_src_s = hold_r;
        start_s  = 1'b0;
        reload_s = 1'b0;
        done_s   = 1'b0;
        if (tx_ready_r) begin
            tx_src_s = 8'h00;
        end else begin
            tx_src_s = hold_r;
        end
        if (state_r == IDLE) begin
            start_s = armed_r & ~cs_dly_r;
        end else begin
            reload_s = ~cs_dly_r & fall_r & reload_pend_r;
            done_s   = ~cs_dly_r & rise_r & (bit_cnt_r == 3'd7);
        end
    end

    // Frame FSM and shift registers; armed_r demands a real cs high after reset before a frame starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            armed_r       <= 1'b0;
            bit_cnt_r     <= 3'd0;
            tx_shift_r    <= 8'h00;
            rx_shift_r    <= 8'h00;
            reload_pend_r <= 1'b0;
            miso_r        <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            if (!sync_vld_r[SYNC_STAGES]) begin
                armed_r <= 1'b0;
            end else if (cs_dly_r) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
            case (state_r)
                IDLE: begin
                    bit_cnt_r     <= 3'd0;
                    reload_pend_r <= 1'b0;
                    if (start_s) begin
                        state_r    <= SHIFT;
                        tx_shift_r <= tx_src_s;
                        miso_r     <= tx_src_s[7];
                        busy_r     <= 1'b1;
                    end else begin
                        miso_r     <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cs_dly_r) begin
                        state_r       <= IDLE;
                        bit_cnt_r     <= 3'd0;
                        rx_shift_r    <= 8'h00;
                        reload_pend_r <= 1'b0;
                        miso_r        <= 1'b0;
                        busy_r        <= 1'b0;
                    end else if (rise_r) begin
                        rx_shift_r <= {rx_shift_r[6:0], mosi_dly_r};
                        bit_cnt_r  <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            reload_pend_r <= 1'b1;
                        end else begin
                            reload_pend_r <= reload_pend_r;
                        end
                    end else if (reload_s) begin
                        tx_shift_r    <= tx_src_s;
                        miso_r        <= tx_src_s[7];
                        reload_pend_r <= 1'b0;
                    end else if (fall_r) begin
                        tx_shift_r <= {tx_shift_r[6:0], 1'b0};
                        miso_r     <= tx_shift_r[6];
                    end else begin
                        tx_shift_r <= tx_shift_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    miso_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Tx holding register: loads only when empty, emptied whenever its byte moves to tx_shift.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_r     <= 8'h00;
            tx_ready_r <= 1'b1;
        end else if (bus.tx_load && tx_ready_r) begin
            hold_r     <= bus.tx_data;
            tx_ready_r <= 1'b0;
        end else if (start_s || reload_s) begin
            tx_ready_r <= 1'b1;
        end else begin
            tx_ready_r <= tx_ready_r;
        end
    end

    // Rx output register: completion beats a same-cycle acknowledge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
        end else if (done_s) begin
            rx_data_r  <= {rx_shift_r[6:0], mosi_dly_r};
            rx_valid_r <= 1'b1;
        end else if (bus.rx_ack) begin
            rx_valid_r <= 1'b0;
        end else begin
            rx_valid_r <= rx_valid_r;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    // Sticky overrun: set when an unacknowledged byte is overwritten, cleared only by rx_ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_overrun_r <= 1'b0;
        end else if (done_s && rx_valid_r && !bus.rx_ack) begin
            rx_overrun_r <= 1'b1;
        end else if (bus.rx_ack) begin
            rx_overrun_r <= 1'b0;
        end else begin
            rx_overrun_r <= rx_overrun_r;
        end
    end
`else
    assign rx_overrun_r = 1'b0;
`endif

    assign bus.miso       = miso_r;
    assign bus.busy       = busy_r;
    assign bus.tx_ready   = tx_ready_r;
    assign bus.rx_data    = rx_data_r;
    assign bus.rx_valid   = rx_valid_r;
    assign bus.rx_overrun = rx_overrun_r;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: mode-0 master at clk/8 with hand-computed expectations.
module tb_spi_slave;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    logic vld_hist [1:4];
    logic [7:0] mi;
    logic exp_ovr;

    spi_slave_if bus ();

    spi_slave #(.SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Master shifts nbits of mo out MSB first; returns what it sampled on miso.
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mo_in);
        mo_in = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = mo[7-i];
            repeat (4) @(negedge clk);
            mo_in[7-i] = bus.miso;
            bus.sclk = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                vld_hist[k] = bus.rx_valid;
            end
            bus.sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        bus.cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        bus.cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] d);
        @(negedge clk);
        bus.tx_data = d;
        bus.tx_load = 1'b1;
        @(negedge clk);
        bus.tx_load = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk);
        bus.rx_ack = 1'b1;
        @(negedge clk);
        bus.rx_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
`ifdef SPI_SLAVE_OVERRUN_EN
        exp_ovr = 1'b1;
`else
        exp_ovr = 1'b0;
`endif
        reset_n     = 1'b0;
        bus.sclk    = 1'b0;
        bus.cs      = 1'b1;
        bus.mosi    = 1'b0;
        bus.tx_data = 8'h00;
        bus.tx_load = 1'b0;
        bus.rx_ack  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_miso", bus.miso, 32'd0);
        check_eq("rst_rx_data", bus.rx_data, 32'h00);
        check_eq("rst_rx_valid", bus.rx_valid, 32'd0);
        check_eq("rst_overrun", bus.rx_overrun, 32'd0);
        check_eq("rst_tx_ready", bus.tx_ready, 32'd1);
        check_eq("rst_busy", bus.busy, 32'd0);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);

        // Basic frame: A5 out, 3C in, latency check on the 8th rise
        load(8'hA5);
        check_eq("t1_tx_ready_after_load", bus.tx_ready, 32'd0);
        cs_low();
        check_eq("t1_busy", bus.busy, 32'd1);
        check_eq("t1_tx_ready_after_start", bus.tx_ready, 32'd1);
        xfer(8'h3C, 8, mi);
        check_eq("t1_miso_byte", mi, 32'hA5);
        check_eq("t1_rx_data", bus.rx_data, 32'h3C);
        check_eq("t1_rx_valid", bus.rx_valid, 32'd1);
        check_eq("t1_valid_before_latency", vld_hist[SYNC+1], 32'd0);
        check_eq("t1_valid_at_latency", vld_hist[SYNC+2], 32'd1);
        cs_high();
        check_eq("t1_busy_idle", bus.busy, 32'd0);
        check_eq("t1_miso_idle", bus.miso, 32'd0);
        ack();
        check_eq("t1_ack_clears", bus.rx_valid, 32'd0);

        // Back-to-back bytes in one frame; empty holding register yields 00
        load(8'hFF);
        cs_low();
        xfer(8'h01, 8, mi);
        check_eq("t2_miso_b0", mi, 32'hFF);
        check_eq("t2_rx_b0", bus.rx_data, 32'h01);
        ack();
        check_eq("t2_ack_mid", bus.rx_valid, 32'd0);
        xfer(8'h02, 8, mi);
        check_eq("t2_miso_b1", mi, 32'h00);
        cs_high();
        check_eq("t2_rx_b1", bus.rx_data, 32'h02);
        check_eq("t2_valid_b1", bus.rx_valid, 32'd1);
        check_eq("t2_no_overrun", bus.rx_overrun, 32'd0);
        ack();

        // Aborted partial byte is discarded
        cs_low();
        xfer(8'hF0, 5, mi);
        cs_high();
        check_eq("t3_valid_after_abort", bus.rx_valid, 32'd0);
        check_eq("t3_data_after_abort", bus.rx_data, 32'h02);
        cs_low();
        xfer(8'h81, 8, mi);
        cs_high();
        check_eq("t3_rx_after_abort", bus.rx_data, 32'h81);
        check_eq("t3_valid_after_abort_byte", bus.rx_valid, 32'd1);
        ack();

        // Two unacknowledged bytes
        cs_low();
        xfer(8'h5A, 8, mi);
        xfer(8'hC3, 8, mi);
        cs_high();
        check_eq("t4_rx_overwritten", bus.rx_data, 32'hC3);
        check_eq("t4_valid", bus.rx_valid, 32'd1);
        check_eq("t4_overrun", bus.rx_overrun, {31'd0, exp_ovr});
        ack();
        check_eq("t4_ack_valid", bus.rx_valid, 32'd0);
        check_eq("t4_ack_overrun", bus.rx_overrun, 32'd0);

        // Second load while full is ignored
        load(8'h11);
        load(8'h22);
        check_eq("t5_tx_ready_full", bus.tx_ready, 32'd0);
        cs_low();
        xfer(8'h00, 8, mi);
        check_eq("t5_first_load_sent", mi, 32'h11);
        cs_high();
        check_eq("t5_tx_ready_after", bus.tx_ready, 32'd1);
        ack();

        // Reset mid-frame, then cs held low must not start a frame
        cs_low();
        load(8'h33);
        xfer(8'h77, 8, mi);
        xfer(8'h99, 4, mi);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("t6_rst_miso", bus.miso, 32'd0);
        check_eq("t6_rst_rx_data", bus.rx_data, 32'h00);
        check_eq("t6_rst_rx_valid", bus.rx_valid, 32'd0);
        check_eq("t6_rst_overrun", bus.rx_overrun, 32'd0);
        check_eq("t6_rst_tx_ready", bus.tx_ready, 32'd1);
        check_eq("t6_rst_busy", bus.busy, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        xfer(8'hE7, 8, mi);
        repeat (6) @(negedge clk);
        check_eq("t6_no_rx_without_cs_toggle", bus.rx_valid, 32'd0);
        check_eq("t6_rx_data_held", bus.rx_data, 32'h00);
        cs_high();
        cs_low();
        xfer(8'hE7, 8, mi);
        cs_high();
        check_eq("t6_rx_after_toggle", bus.rx_data, 32'hE7);
        check_eq("t6_valid_after_toggle", bus.rx_valid, 32'd1);
        ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
